// File: rtl/mock8080_pkg.sv
// Shared widths and RAM controller state encoding for the mock 8080 system.
package mock8080_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_state_t;
endpackage

// File: rtl/slave_clk_edge.sv
// Rising-edge detector for the slave clock, sampled on the master clock.
module slave_clk_edge (
  input  logic clk_qzt,
  input  logic reset,
  input  logic clk_in,
  output logic clk_rise
);
  logic clk_in_old_reg;

  always_ff @(posedge clk_qzt) begin
    if (reset) clk_in_old_reg <= 1'b0;
    else       clk_in_old_reg <= clk_in;
  end

  assign clk_rise = clk_in & ~clk_in_old_reg;
endmodule

// File: rtl/mock_ram.sv
// 256x8 CPU-side RAM with a handshaked preload port and a full-array clear engine.
module mock_ram #(
  parameter int ADDR_W = mock8080_pkg::ADDR_W,
  parameter int DATA_W = mock8080_pkg::DATA_W
) (
  input  logic              clk_qzt,
  input  logic              reset,
  input  logic              clk_in,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              we,
  output logic [DATA_W-1:0] rd_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              clr_req,
  output logic              busy
);
  import mock8080_pkg::*;

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;
  ram_state_t        state_reg;
  logic              busy_reg;
  logic              clk_rise;
  logic              cpu_wr;
  logic              ld_fire;
  logic              clear_wr;

  slave_clk_edge u_edge (
    .clk_qzt  (clk_qzt),
    .reset    (reset),
    .clk_in   (clk_in),
    .clk_rise (clk_rise)
  );

  assign cpu_wr   = en & clk_rise & we & (state_reg == IDLE);
  assign ld_ready = (state_reg == IDLE) & ~cpu_wr;
  assign ld_fire  = ld_valid & ld_ready;
  // Reset must stop the sweep on the very cycle it is asserted.
  assign clear_wr = (state_reg == CLEAR) & ~reset;

  // Single write port: clear sweep, then CPU, then loader.
  always_ff @(posedge clk_qzt) begin
    if (clear_wr)     mem[clr_cnt_reg] <= '0;
    else if (cpu_wr)  mem[addr]        <= wr_data;
    else if (ld_fire) mem[ld_addr]     <= ld_data;
  end

  always_ff @(posedge clk_qzt) begin
    if (reset)   rd_data_reg <= '0;
    else if (en) rd_data_reg <= mem[addr];
  end

  always_ff @(posedge clk_qzt) begin
    if (reset) begin
      state_reg   <= IDLE;
      clr_cnt_reg <= '0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clr_req) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == {ADDR_W{1'b1}}) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rd_data = rd_data_reg;
  assign busy    = busy_reg;
endmodule

// File: tb/tb_mock_ram.sv
// Scoreboard bench for mock_ram: expected read data is queued as reads are issued.
`timescale 1ns/1ps
module tb_mock_ram;
  logic       clk_qzt = 1'b0;
  logic       reset   = 1'b1;
  logic       clk_in  = 1'b0;
  logic       en      = 1'b0;
  logic [7:0] addr    = '0;
  logic [7:0] wr_data = '0;
  logic       we      = 1'b0;
  logic [7:0] rd_data;
  logic       ld_valid = 1'b0;
  logic       ld_ready;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       clr_req = 1'b0;
  logic       busy;

  logic [7:0] ref_mem [256];
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_qzt = ~clk_qzt;

  mock_ram dut (
    .clk_qzt  (clk_qzt),
    .reset    (reset),
    .clk_in   (clk_in),
    .en       (en),
    .addr     (addr),
    .wr_data  (wr_data),
    .we       (we),
    .rd_data  (rd_data),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .clr_req  (clr_req),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk_qzt);
    #1;
  endtask

  // Queue the model's value for a read, then advance one cycle.
  task automatic issue_read(input logic [7:0] a);
    en   = 1'b1;
    we   = 1'b0;
    addr = a;
    exp_q.push_back(ref_mem[a]);
    tick();
  endtask

  task automatic preload_ff();
    en       = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_addr = 8'(i);
      ld_data = 8'hFF;
      tick();
      ref_mem[i] = 8'hFF;
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", rd_data);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
    else n_pass++;
    n_checks++;
    if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready got=%b exp=1", ld_ready);
    else n_pass++;
    reset = 1'b0;
    tick();
    e = 8'h00;
    $display("test_reset done rd_data=%h busy=%b exp_rd=%h", rd_data, busy, e);
  endtask

  task automatic test_loader();
    logic [7:0] la [3];
    logic [7:0] ld [3];
    logic [7:0] e;
    la[0] = 8'h00; ld[0] = 8'h06;
    la[1] = 8'h01; ld[1] = 8'h2A;
    la[2] = 8'h02; ld[2] = 8'h80;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_addr  = la[i];
      ld_data  = ld[i];
      #1;
      n_checks++;
      if (ld_ready !== 1'b1) $display("FAIL loader_ready[%0d] got=%b exp=1", i, ld_ready);
      else n_pass++;
      tick();
      ref_mem[la[i]] = ld[i];
      $display("loader write addr=%h data=%h", la[i], ld[i]);
    end
    ld_valid = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      issue_read(la[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (rd_data !== e) $display("FAIL loader_read addr=%h got=%h exp=%h", la[i], rd_data, e);
      else n_pass++;
    end
  endtask

  task automatic test_cpu_write_once();
    logic [7:0] e;
    en = 1'b1; we = 1'b1; addr = 8'h10; wr_data = 8'h55; clk_in = 1'b0;
    tick();
    clk_in = 1'b1;
    #1;
    n_checks++;
    if (ld_ready !== 1'b0) $display("FAIL cpu_edge_ld_ready got=%b exp=0", ld_ready);
    else n_pass++;
    tick();
    ref_mem[8'h10] = 8'h55;
    n_checks++;
    if (ld_ready !== 1'b1) $display("FAIL cpu_high_ld_ready got=%b exp=1", ld_ready);
    else n_pass++;
    tick();
    wr_data = 8'h66;
    for (int i = 0; i < 3; i++) tick();
    clk_in = 1'b0;
    we     = 1'b0;
    issue_read(8'h10);
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data !== e) $display("FAIL cpu_write_once got=%h exp=%h", rd_data, e);
    else n_pass++;
    $display("cpu write addr=10 read=%h exp=%h", rd_data, e);
  endtask

  task automatic test_contention();
    logic [7:0] e;
    clk_in = 1'b0; we = 1'b0;
    tick();
    en = 1'b1; we = 1'b1; addr = 8'h20; wr_data = 8'hAA; clk_in = 1'b1;
    ld_valid = 1'b1; ld_addr = 8'h21; ld_data = 8'hBB;
    #1;
    n_checks++;
    if (ld_ready !== 1'b0) $display("FAIL contention_ld_ready got=%b exp=0", ld_ready);
    else n_pass++;
    tick();
    ref_mem[8'h20] = 8'hAA;
    n_checks++;
    if (ld_ready !== 1'b1) $display("FAIL contention_retry_ready got=%b exp=1", ld_ready);
    else n_pass++;
    tick();
    ref_mem[8'h21] = 8'hBB;
    ld_valid = 1'b0; we = 1'b0; clk_in = 1'b0;
    issue_read(8'h20);
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data !== e) $display("FAIL contention_cpu got=%h exp=%h", rd_data, e);
    else n_pass++;
    issue_read(8'h21);
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data !== e) $display("FAIL contention_loader got=%h exp=%h", rd_data, e);
    else n_pass++;
    $display("contention done mem[21]=%h", rd_data);
  endtask

  task automatic test_clear();
    int cnt;
    int rdy_bad;
    logic [7:0] e;
    logic [7:0] ra [4];
    ra[0] = 8'h00; ra[1] = 8'h7F; ra[2] = 8'hFF; ra[3] = 8'h30;
    preload_ff();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    rdy_bad = 0;
    while (busy === 1'b1 && cnt < 400) begin
      if (cnt == 100) begin
        en = 1'b1; we = 1'b1; addr = 8'h30; wr_data = 8'h12; clk_in = 1'b1;
      end else begin
        we = 1'b0; clk_in = 1'b0;
      end
      #1;
      if (ld_ready !== 1'b0) rdy_bad++;
      cnt++;
      tick();
    end
    we = 1'b0; clk_in = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    n_checks++;
    if (cnt != 256) $display("FAIL clear_busy_cycles got=%0d exp=256", cnt);
    else n_pass++;
    n_checks++;
    if (rdy_bad != 0) $display("FAIL clear_ld_ready got=%0d_high_cycles exp=0", rdy_bad);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      issue_read(ra[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (rd_data !== e) $display("FAIL clear_read addr=%h got=%h exp=%h", ra[i], rd_data, e);
      else n_pass++;
    end
    $display("clear done busy_cycles=%0d", cnt);
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] e;
    logic [7:0] ra [4];
    ra[0] = 8'h00; ra[1] = 8'h63; ra[2] = 8'h64; ra[3] = 8'hFF;
    preload_ff();
    en = 1'b1; addr = 8'hFF;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) ref_mem[i] = 8'h00;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL midclear_busy got=%b exp=0", busy);
    else n_pass++;
    n_checks++;
    if (rd_data !== 8'h00) $display("FAIL midclear_rd_data got=%h exp=00", rd_data);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      issue_read(ra[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (rd_data !== e) $display("FAIL midclear_read addr=%h got=%h exp=%h", ra[i], rd_data, e);
      else n_pass++;
    end
    $display("reset mid-clear done");
  endtask

  task automatic test_read_first();
    logic [7:0] e;
    en = 1'b1; we = 1'b1; addr = 8'h40; clk_in = 1'b0;
    tick();
    wr_data = 8'h11; clk_in = 1'b1;
    exp_q.push_back(ref_mem[8'h40]);
    tick();
    ref_mem[8'h40] = 8'h11;
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data !== e) $display("FAIL rf_first_old got=%h exp=%h", rd_data, e);
    else n_pass++;
    clk_in = 1'b0;
    exp_q.push_back(ref_mem[8'h40]);
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data !== e) $display("FAIL rf_first_new got=%h exp=%h", rd_data, e);
    else n_pass++;
    wr_data = 8'h22; clk_in = 1'b1;
    exp_q.push_back(ref_mem[8'h40]);
    tick();
    ref_mem[8'h40] = 8'h22;
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data !== e) $display("FAIL rf_second_old got=%h exp=%h", rd_data, e);
    else n_pass++;
    clk_in = 1'b0; we = 1'b0;
    exp_q.push_back(ref_mem[8'h40]);
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data !== e) $display("FAIL rf_second_new got=%h exp=%h", rd_data, e);
    else n_pass++;
    en = 1'b0; addr = 8'h10;
    exp_q.push_back(8'h22);
    tick();
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (rd_data !== e) $display("FAIL en_hold got=%h exp=%h", rd_data, e);
    else n_pass++;
    $display("read-first and hold done rd_data=%h", rd_data);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_loader();
    test_cpu_write_once();
    test_contention();
    test_clear();
    test_reset_mid_clear();
    test_read_first();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
